serial_sub_sched: RTL and testbench

Shares one bit-serial 1-bit full-subtractor cell between two requesters. The cell's logic is the same mux-style difference/borrow function as the team's half/full subtractor blocks. The block arbitrates round-robin, captures the winner's WIDTH-bit operands and steps the subtraction LSB-first with a registered borrow. It returns the difference, borrow-out and requester ID with a one-cycle done pulse. It sits between the subtractor datapath and any two clients that need A−B without a dedicated parallel subtractor.

---
 rtl/serial_sub_sched.sv | 112 +++++++++++
 tb/tb_serial_sub_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_sched.sv
// Round-robin sharing of one bit-serial full-subtractor cell between two requesters.
// Operands are captured at grant, subtracted LSB-first, and the result is posted with a done pulse.
module serial_sub_sched #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q;
  logic [WIDTH-2:0] sr_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             last_q;

  logic             win;
  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] sr_ext;

  // Ties go to the requester that was not served last.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~last_q;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  always_comb begin
    d_bit  = sa_q[0] ^ sb_q[0] ^ br_q;
    br_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    sr_ext = {d_bit, sr_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            sa_q    <= win ? a1 : a0;
            sb_q    <= win ? b1 : b0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            last_q  <= win;
            gnt0    <= ~win;
            gnt1    <= win;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          sr_q  <= sr_ext[WIDTH-1:1];
          br_q  <= br_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            diff    <= sr_ext;
            bout    <= br_nxt;
            done_id <= last_q;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_sched.sv
// Directed bench for serial_sub_sched: vector table, round-robin, late request,
// mid-run reset and an exhaustive 4-bit sweep.
module tb_serial_sub_sched;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, done, done_id, bout;
  logic [W-1:0] diff;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_on  = 1'b0;

  serial_sub_sched #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .diff    (diff),
    .bout    (bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grants and done must never overlap.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
      chk("done_vs_gnt", {31'd0, done & (gnt0 | gnt1)}, 32'd0);
    end
  end

  task automatic wait_gnt(input logic id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((id == 1'b0 && gnt0) || (id == 1'b1 && gnt1)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  // One full transaction; leaves the bench in the IDLE cycle after done.
  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_d, input logic exp_bo, input bit verbose);
    bit ok;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; end
    wait_gnt(id, ok);
    req0 = 1'b0;
    req1 = 1'b0;
    if (verbose) chk("busy_at_gnt", {31'd0, busy}, 32'd1);
    for (int k = 1; k < int'(W); k++) begin
      tick();
      if (verbose) chk("no_early_done", {31'd0, done}, 32'd0);
    end
    tick();
    chk("done_at_g_plus_w", {31'd0, done}, 32'd1);
    chk("diff", {28'd0, diff}, {28'd0, exp_d});
    chk("bout", {31'd0, bout}, {31'd0, exp_bo});
    chk("done_id", {31'd0, done_id}, {31'd0, id});
    tick();
    if (verbose) begin
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("busy_clear", {31'd0, busy}, 32'd0);
      chk("diff_held", {28'd0, diff}, {28'd0, exp_d});
    end
  endtask

  initial begin
    bit ok;
    int prev;
    logic exp_id;

    vt[0] = '{id: 1'b0, a: 4'd9,  b: 4'd3,  d: 4'd6,  bo: 1'b0};
    vt[1] = '{id: 1'b1, a: 4'd3,  b: 4'd9,  d: 4'd10, bo: 1'b1};
    vt[2] = '{id: 1'b1, a: 4'd0,  b: 4'd15, d: 4'd1,  bo: 1'b1};
    vt[3] = '{id: 1'b1, a: 4'd7,  b: 4'd7,  d: 4'd0,  bo: 1'b0};
    vt[4] = '{id: 1'b0, a: 4'd15, b: 4'd0,  d: 4'd15, bo: 1'b0};

    #12;
    chk("rst_outputs", {24'd0, gnt0, gnt1, busy, done, done_id, bout, 2'd0}, 32'd0);
    chk("rst_diff", {28'd0, diff}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    mon_on = 1'b1;

    for (int i = 0; i < 5; i++) do_op(vt[i].id, vt[i].a, vt[i].b, vt[i].d, vt[i].bo, 1'b1);

    // Fresh reset so the tie-break pointer starts at its reset value.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req0 = 1'b1; a0 = 4'd12; b0 = 4'd5;
    req1 = 1'b1; a1 = 4'd2;  b1 = 4'd6;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      exp_id = logic'(i % 2);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (done) begin ok = 1'b1; break; end
      end
      chk("rr_done_seen", {31'd0, ok}, 32'd1);
      chk("rr_order", {31'd0, done_id}, {31'd0, exp_id});
      chk("rr_diff", {28'd0, diff}, exp_id ? 32'd12 : 32'd7);
      chk("rr_bout", {31'd0, bout}, exp_id ? 32'd1 : 32'd0);
      if (i > 0) chk("rr_spacing", cyc - prev, 32'd6);
      prev = cyc;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();

    // Request arriving during RUN waits for the IDLE cycle after done.
    req0 = 1'b1; a0 = 4'd14; b0 = 4'd4;
    wait_gnt(1'b0, ok);
    req0 = 1'b0;
    req1 = 1'b1; a1 = 4'd8; b1 = 4'd1;
    for (int k = 1; k <= int'(W) + 1; k++) begin
      tick();
      chk("late_no_gnt1", {31'd0, gnt1}, 32'd0);
      if (k == int'(W)) begin
        chk("late_done0", {31'd0, done}, 32'd1);
        chk("late_diff0", {28'd0, diff}, 32'd10);
      end
    end
    tick();
    chk("late_gnt1_at_done_plus_2", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    for (int k = 0; k < int'(W); k++) tick();
    chk("late_done1", {31'd0, done}, 32'd1);
    chk("late_diff1", {28'd0, diff}, 32'd7);
    chk("late_id1", {31'd0, done_id}, 32'd1);
    tick();

    // Asynchronous reset two cycles into RUN discards the operation.
    req0 = 1'b1; a0 = 4'd9; b0 = 4'd3;
    wait_gnt(1'b0, ok);
    req0 = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {24'd0, gnt0, gnt1, busy, done, done_id, bout, 2'd0}, 32'd0);
    chk("async_rst_diff", {28'd0, diff}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("no_done_after_rst", {31'd0, done}, 32'd0);
    end
    do_op(1'b0, 4'd5, 4'd2, 4'd3, 1'b0, 1'b1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(1'b0, W'(a), W'(b), W'((a - b) & 15), (a < b), 1'b0);
      end
    end

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
